// File: rtl/lbist_pkg.sv
// Shared definitions for the logic BIST controller: FSM state encoding and
// the MISR request width helper.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lbist_state_e;

  // Width of the MISR hash-count field; the request port carries one extra
  // bit so that a full-capacity count (MAX_OUTPUTS_TO_HASH) is representable.
  function automatic int calc_misr_msg_bits(input int max_outputs_to_hash);
    return $clog2(max_outputs_to_hash);
  endfunction

endpackage

// File: rtl/lbist_controller.sv
// Logic BIST controller: for each stored seed, hands the seed to the LFSR and
// a hash count to the MISR, waits for the resulting signature, compares it
// with the golden value and accumulates a per-seed pass mask for the host.
module lbist_controller
  import lbist_pkg::*;
#(
  parameter int SEED_BITS           = 32,
  parameter int SIGNATURE_BITS      = 32,
  parameter int NUM_SEEDS           = 8,
  parameter int MAX_OUTPUTS_TO_HASH = 32,
  parameter int NUM_HASHES          = 16,
  parameter logic [NUM_SEEDS-1:0][SEED_BITS-1:0] LFSR_SEEDS = {
    32'h9e37_79b9, 32'h7f4a_7c15, 32'h85eb_ca6b, 32'hc2b2_ae35,
    32'h27d4_eb2f, 32'h1656_67b1, 32'hd3a2_646c, 32'hfd70_46c5
  },
  parameter logic [NUM_SEEDS-1:0][SIGNATURE_BITS-1:0] MISR_SIGNATURES = {
    32'h0bad_cafe, 32'h1357_9bdf, 32'h2468_ace0, 32'h3c3c_5a5a,
    32'h4b1d_f00d, 32'h5eed_1234, 32'h6a6a_9595, 32'h7777_0001
  },
  localparam int MISR_MSG_BITS = calc_misr_msg_bits(MAX_OUTPUTS_TO_HASH)
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      lbist_req_val,
  output logic                      lbist_req_rdy,
  output logic                      lbist_resp_val,
  output logic [NUM_SEEDS-1:0]      lbist_resp_msg,
  input  logic                      lbist_resp_rdy,

  output logic                      lfsr_resp_val,
  output logic [SEED_BITS-1:0]      lfsr_resp_msg,
  input  logic                      lfsr_resp_rdy,

  output logic                      misr_req_val,
  output logic [MISR_MSG_BITS:0]    misr_req_msg,
  input  logic                      misr_req_rdy,

  input  logic                      misr_resp_val,
  input  logic [SIGNATURE_BITS-1:0] misr_resp_msg,
  output logic                      misr_resp_rdy
);

  localparam int IDX_BITS = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_SEEDS - 1);

  lbist_state_e          state_q, state_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic                  lfsr_sent_q, lfsr_sent_d;
  logic                  misr_sent_q, misr_sent_d;
  logic [NUM_SEEDS-1:0]  mask_q, mask_d;

  // State, seed index, sent flags and pass mask registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lfsr_sent_q <= 1'b0;
      misr_sent_q <= 1'b0;
      mask_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      lfsr_sent_q <= lfsr_sent_d;
      misr_sent_q <= misr_sent_d;
      mask_q      <= mask_d;
    end
  end

  // Next-state and handshake outputs; a peer transfer is val && rdy.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    idx_d          = idx_q;
    lfsr_sent_d    = lfsr_sent_q;
    misr_sent_d    = misr_sent_q;
    mask_d         = mask_q;
    lbist_req_rdy  = 1'b0;
    lbist_resp_val = 1'b0;
    lbist_resp_msg = '0;
    lfsr_resp_val  = 1'b0;
    lfsr_resp_msg  = '0;
    misr_req_val   = 1'b0;
    misr_req_msg   = '0;
    misr_resp_rdy  = 1'b0;

    unique case (state_q)
      IDLE: begin
        lbist_req_rdy = 1'b1;
        if (lbist_req_val) begin
          state_d     = SEND;
          idx_d       = '0;
          mask_d      = '0;
          lfsr_sent_d = 1'b0;
          misr_sent_d = 1'b0;
        end
      end

      SEND: begin
        // Each channel keeps val up until its own transfer; messages stay
        // stable for the whole state.
        lfsr_resp_val = !lfsr_sent_q;
        lfsr_resp_msg = LFSR_SEEDS[idx_q];
        misr_req_val  = !misr_sent_q;
        misr_req_msg  = (MISR_MSG_BITS + 1)'(NUM_HASHES);
        if (lfsr_resp_val && lfsr_resp_rdy) lfsr_sent_d = 1'b1;
        if (misr_req_val && misr_req_rdy)   misr_sent_d = 1'b1;
        if (lfsr_sent_q && misr_sent_q)     state_d     = WAIT;
      end

      WAIT: begin
        misr_resp_rdy = 1'b1;
        if (misr_resp_val) begin
          mask_d[idx_q] = (misr_resp_msg == MISR_SIGNATURES[idx_q]);
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d       = idx_q + IDX_BITS'(1);
            lfsr_sent_d = 1'b0;
            misr_sent_d = 1'b0;
            state_d     = SEND;
          end
        end
      end

      DONE: begin
        lbist_resp_val = 1'b1;
        lbist_resp_msg = mask_q;
        if (lbist_resp_rdy) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lbist_controller.sv
// Directed bench for lbist_controller with four seeds. The MISR peer is a
// small model returning the golden signature for the seed it is on, with an
// optional single-bit corruption on one chosen seed.
module tb_lbist_controller;

  localparam logic [31:0] SEED0 = 32'ha5a5_0001;
  localparam logic [31:0] SEED1 = 32'hb4b4_0002;
  localparam logic [31:0] SEED2 = 32'hc3c3_0003;
  localparam logic [31:0] SEED3 = 32'hd2d2_0004;
  localparam logic [31:0] SIG0  = 32'h1111_1111;
  localparam logic [31:0] SIG1  = 32'h2222_2222;
  localparam logic [31:0] SIG2  = 32'h3333_3333;
  localparam logic [31:0] SIG3  = 32'h4444_4444;

  logic        clk = 1'b0;
  logic        reset;
  logic        lbist_req_val;
  logic        lbist_req_rdy;
  logic        lbist_resp_val;
  logic [3:0]  lbist_resp_msg;
  logic        lbist_resp_rdy;
  logic        lfsr_resp_val;
  logic [31:0] lfsr_resp_msg;
  logic        lfsr_resp_rdy;
  logic        misr_req_val;
  logic [5:0]  misr_req_msg;
  logic        misr_req_rdy;
  logic        misr_resp_val;
  logic [31:0] misr_resp_msg;
  logic        misr_resp_rdy;

  int n_checks = 0;
  int n_errors = 0;
  int cycles;

  logic [2:0]  tb_idx;
  logic [2:0]  bad_idx;
  logic [31:0] sig_sel;

  always #5 clk = ~clk;

  lbist_controller #(
    .SEED_BITS          (32),
    .SIGNATURE_BITS     (32),
    .NUM_SEEDS          (4),
    .MAX_OUTPUTS_TO_HASH(32),
    .NUM_HASHES         (16),
    .LFSR_SEEDS         ({SEED3, SEED2, SEED1, SEED0}),
    .MISR_SIGNATURES    ({SIG3, SIG2, SIG1, SIG0})
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lbist_req_val (lbist_req_val),
    .lbist_req_rdy (lbist_req_rdy),
    .lbist_resp_val(lbist_resp_val),
    .lbist_resp_msg(lbist_resp_msg),
    .lbist_resp_rdy(lbist_resp_rdy),
    .lfsr_resp_val (lfsr_resp_val),
    .lfsr_resp_msg (lfsr_resp_msg),
    .lfsr_resp_rdy (lfsr_resp_rdy),
    .misr_req_val  (misr_req_val),
    .misr_req_msg  (misr_req_msg),
    .misr_req_rdy  (misr_req_rdy),
    .misr_resp_val (misr_resp_val),
    .misr_resp_msg (misr_resp_msg),
    .misr_resp_rdy (misr_resp_rdy)
  );

  // MISR peer: tracks which seed's signature is due from completed transfers.
  always @(posedge clk or posedge reset) begin
    if (reset)                               tb_idx <= 3'd0;
    else if (lbist_req_val && lbist_req_rdy) tb_idx <= 3'd0;
    else if (misr_resp_val && misr_resp_rdy) tb_idx <= tb_idx + 3'd1;
  end

  always_comb begin
    sig_sel = SIG0;
    case (tb_idx[1:0])
      2'd0: sig_sel = SIG0;
      2'd1: sig_sel = SIG1;
      2'd2: sig_sel = SIG2;
      2'd3: sig_sel = SIG3;
      default: sig_sel = SIG0;
    endcase
  end

  assign misr_resp_msg = sig_sel ^ ((tb_idx == bad_idx) ? 32'h1 : 32'h0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"},   lbist_req_rdy,  1);
    check({tag, "_resp_val"},  lbist_resp_val, 0);
    check({tag, "_resp_msg"},  lbist_resp_msg, 0);
    check({tag, "_lfsr_val"},  lfsr_resp_val,  0);
    check({tag, "_lfsr_msg"},  lfsr_resp_msg,  0);
    check({tag, "_misr_val"},  misr_req_val,   0);
    check({tag, "_misr_msg"},  misr_req_msg,   0);
    check({tag, "_misr_rrdy"}, misr_resp_rdy,  0);
  endtask

  task automatic start_run();
    lbist_req_val = 1'b1;
    step();
    lbist_req_val = 1'b0;
  endtask

  // Bounded wait for the result; cycles continues from its current value.
  task automatic wait_done(input string tag);
    while (lbist_resp_val !== 1'b1 && cycles < 60) begin
      step();
      cycles++;
    end
    check({tag, "_resp_val"}, lbist_resp_val, 1);
  endtask

  task automatic ack_result(input string tag);
    lbist_resp_rdy = 1'b1;
    step();
    lbist_resp_rdy = 1'b0;
    check({tag, "_idle_req_rdy"},  lbist_req_rdy,  1);
    check({tag, "_idle_resp_val"}, lbist_resp_val, 0);
    check({tag, "_idle_resp_msg"}, lbist_resp_msg, 0);
  endtask

  initial begin
    reset          = 1'b1;
    lbist_req_val  = 1'b0;
    lbist_resp_rdy = 1'b0;
    lfsr_resp_rdy  = 1'b1;
    misr_req_rdy   = 1'b1;
    misr_resp_val  = 1'b1;
    bad_idx        = 3'd7;
    step();
    step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // All peers ready, all signatures golden; misr_resp_val held high all run.
    check("a_idle_misr_rrdy", misr_resp_rdy,  0);
    check("a_idle_resp_msg",  lbist_resp_msg, 0);
    start_run();
    check("a_send_lfsr_val",  lfsr_resp_val,  1);
    check("a_send_lfsr_msg",  lfsr_resp_msg,  SEED0);
    check("a_send_misr_val",  misr_req_val,   1);
    check("a_send_misr_msg",  misr_req_msg,   16);
    check("a_send_misr_rrdy", misr_resp_rdy,  0);
    check("a_send_req_rdy",   lbist_req_rdy,  0);
    step();
    check("a_sent_lfsr_val",  lfsr_resp_val,  0);
    check("a_sent_misr_val",  misr_req_val,   0);
    check("a_sent_misr_rrdy", misr_resp_rdy,  0);
    step();
    check("a_wait_misr_rrdy", misr_resp_rdy,  1);
    check("a_wait_resp_msg",  lbist_resp_msg, 0);
    step();
    check("a_seed1_lfsr_msg", lfsr_resp_msg,  SEED1);
    cycles = 3;
    wait_done("a");
    check("a_latency",  cycles,         12);
    check("a_mask",     lbist_resp_msg, 4'b1111);
    ack_result("a");

    // Seed 2 signature off by one bit; host stalls the result for 10 cycles.
    bad_idx = 3'd2;
    start_run();
    cycles = 0;
    wait_done("b");
    check("b_latency", cycles,         12);
    check("b_mask",    lbist_resp_msg, 4'b1011);
    for (int i = 0; i < 10; i++) begin
      check("b_hold_val", lbist_resp_val, 1);
      check("b_hold_msg", lbist_resp_msg, 4'b1011);
      step();
    end
    check("b_still_done", lbist_resp_val, 1);
    ack_result("b");
    bad_idx = 3'd7;

    // LFSR stalls for 5 cycles while the MISR request completes at once.
    lfsr_resp_rdy = 1'b0;
    start_run();
    check("c_lfsr_val0", lfsr_resp_val, 1);
    check("c_misr_val0", misr_req_val,  1);
    step();
    check("c_misr_val_drop", misr_req_val,  0);
    check("c_lfsr_val_held", lfsr_resp_val, 1);
    check("c_lfsr_msg_held", lfsr_resp_msg, SEED0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("c_stall_lfsr_val", lfsr_resp_val, 1);
      check("c_stall_lfsr_msg", lfsr_resp_msg, SEED0);
      check("c_stall_misr_val", misr_req_val,  0);
      check("c_stall_no_wait",  misr_resp_rdy, 0);
    end
    lfsr_resp_rdy = 1'b1;
    step();
    check("c_sent_lfsr_val", lfsr_resp_val, 0);
    check("c_sent_no_wait",  misr_resp_rdy, 0);
    step();
    check("c_wait_rrdy", misr_resp_rdy, 1);
    cycles = 0;
    wait_done("c");
    check("c_tail_latency", cycles,         10);
    check("c_mask",         lbist_resp_msg, 4'b1111);
    ack_result("c");

    // Reset during WAIT of seed 1, then a fresh run from seed 0.
    start_run();
    for (int i = 0; i < 5; i++) step();
    check("d_in_wait_seed1", misr_resp_rdy, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("d_rst");
    step();
    reset = 1'b0;
    step();
    start_run();
    check("d_restart_lfsr_msg", lfsr_resp_msg, SEED0);
    cycles = 0;
    wait_done("d");
    check("d_latency", cycles,         12);
    check("d_mask",    lbist_resp_msg, 4'b1111);
    ack_result("d");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
